serial_rx8: RTL and testbench

SERIAL_RX8 -- requirements
Module: serial_rx8

---
 rtl/serial_rx8.sv | 77 +++++++
 tb/tb_serial_rx8.sv | 128 ++++++++++++
 2 files changed

// File: rtl/serial_rx8.sv
// Serial byte receiver: one start bit, eight data bits and one stop bit, one bit per clock.
// Emits a single-cycle valid or frame_err pulse when each frame ends.
module serial_rx8 #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sin,
  output logic [7:0] dout,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] STOP  = 2'd2;

  logic [1:0] state;
  logic [2:0] count;
  logic [7:0] shreg;
  logic [7:0] shreg_next;

  // The first data bit ends up in bit 0 when LSB-first, otherwise in bit 7.
  always_comb begin
    shreg_next = shreg;
    if (LSB_FIRST != 0)
      shreg_next = {sin, shreg[7:1]};
    else
      shreg_next = {shreg[6:0], sin};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 3'd0;
      shreg     <= 8'h00;
      dout      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!sin) begin
            state <= SHIFT;
            count <= 3'd0;
          end
        end
        SHIFT: begin
          shreg <= shreg_next;
          count <= count + 3'd1;
          if (count == 3'd7)
            state <= STOP;
        end
        STOP: begin
          // A low stop bit returns to IDLE directly, so it is never read as a new start bit.
          if (sin) begin
            dout  <= shreg;
            valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          count <= 3'd0;
        end
      endcase
    end
  end

  assign busy = (state == SHIFT) || (state == STOP);

endmodule

// File: tb/tb_serial_rx8.sv
// Directed bench for serial_rx8: one LSB-first and one MSB-first instance share the same serial line.
module tb_serial_rx8;

  logic       clk;
  logic       reset;
  logic       sin;
  logic [7:0] dout_l;
  logic       valid_l;
  logic       frame_err_l;
  logic       busy_l;
  logic [7:0] dout_m;
  logic       valid_m;
  logic       frame_err_m;
  logic       busy_m;

  int compared;
  int mismatched;

  serial_rx8 #(.LSB_FIRST(1)) dut_lsb (
    .clk(clk), .reset(reset), .sin(sin),
    .dout(dout_l), .valid(valid_l), .frame_err(frame_err_l), .busy(busy_l)
  );

  serial_rx8 #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .reset(reset), .sin(sin),
    .dout(dout_m), .valid(valid_m), .frame_err(frame_err_m), .busy(busy_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] status();
    return {2'b00, busy_l, valid_l, frame_err_l, busy_m, valid_m, frame_err_m};
  endfunction

  function automatic logic [7:0] st(input logic b, input logic v, input logic f);
    return {2'b00, b, v, f, b, v, f};
  endfunction

  task automatic applyStimulus(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Start bit, data bits in the order given by 'data' bit 0 first, then the stop bit.
  task automatic sendFrame(input logic [7:0] data, input logic stop_bit,
                           input logic [7:0] exp_l, input logic [7:0] exp_m);
    applyStimulus(1'b0);
    checkOutput("start_status", status(), st(1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(data[i]);
      checkOutput("data_status", status(), st(1'b1, 1'b0, 1'b0));
    end
    applyStimulus(stop_bit);
    checkOutput("stop_status", status(), st(1'b0, stop_bit, !stop_bit));
    checkOutput("dout_lsb", dout_l, exp_l);
    checkOutput("dout_msb", dout_m, exp_m);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    sin        = 1'b1;
    reset      = 1'b1;

    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("reset_status", status(), st(1'b0, 1'b0, 1'b0));
    checkOutput("reset_dout_lsb", dout_l, 8'h00);
    checkOutput("reset_dout_msb", dout_m, 8'h00);
    reset = 1'b0;

    // Line idle high for 50 cycles
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1);
      checkOutput("idle_status", status(), st(1'b0, 1'b0, 1'b0));
      checkOutput("idle_dout", {dout_l[3:0], dout_m[3:0]} | {dout_l[7:4], dout_m[7:4]}, 8'h00);
    end

    // Data bits 0,1,0,1,0,0,1,0 on the wire: LSB-first 0x4A, MSB-first 0x52
    sendFrame(8'h4A, 1'b1, 8'h4A, 8'h52);
    applyStimulus(1'b1);
    checkOutput("valid_one_cycle", status(), st(1'b0, 1'b0, 1'b0));

    // 0xFF with a low stop bit: error pulse, dout unchanged, no new frame started
    sendFrame(8'hFF, 1'b0, 8'h4A, 8'h52);
    applyStimulus(1'b1);
    checkOutput("ferr_one_cycle", status(), st(1'b0, 1'b0, 1'b0));
    checkOutput("ferr_hold_lsb", dout_l, 8'h4A);
    checkOutput("ferr_hold_msb", dout_m, 8'h52);

    // Back-to-back frames, no idle gap
    sendFrame(8'hA5, 1'b1, 8'hA5, 8'hA5);
    sendFrame(8'h3C, 1'b1, 8'h3C, 8'h3C);
    applyStimulus(1'b1);
    checkOutput("b2b_after", status(), st(1'b0, 1'b0, 1'b0));
    checkOutput("b2b_dout_hold", dout_l, 8'h3C);

    // Reset at data bit 4 aborts the frame silently
    applyStimulus(1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1);
    reset = 1'b1;
    applyStimulus(1'b0);
    reset = 1'b0;
    checkOutput("abort_status", status(), st(1'b0, 1'b0, 1'b0));
    checkOutput("abort_dout_lsb", dout_l, 8'h00);
    checkOutput("abort_dout_msb", dout_m, 8'h00);

    // First low bit after reset release is a start bit
    sendFrame(8'h81, 1'b1, 8'h81, 8'h81);
    applyStimulus(1'b1);
    checkOutput("final_status", status(), st(1'b0, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
